updown_count_ctrl: RTL

//  Sequencing controller for the n-bit up/down counter datapath. Latches a run

---
 rtl/updown_ctrl_pkg.sv | 14 +
 rtl/updown_count_ctrl_if.sv | 28 ++
 rtl/updown_count_core.sv | 26 ++
 rtl/updown_count_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/updown_ctrl_pkg.sv
// rtl/updown_ctrl_pkg.sv - shared state encoding and direction constants for the up/down count controller
package updown_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/updown_count_ctrl_if.sv
// rtl/updown_count_ctrl_if.sv - control/status bundle between a host and the up/down count controller
interface updown_count_ctrl_if #(
   parameter int N       = 4,
   parameter int PRESC_W = 8
);
   logic               start;
   logic               stop;
   logic               hold;
   logic               dir;
   logic               auto_reload;
   logic [N-1:0]       load_val;
   logic [N-1:0]       limit;
   logic [PRESC_W-1:0] presc;
   logic [N-1:0]       q;
   logic               busy;
   logic               done;
   logic               tc_pulse;

   modport master (
      output start, stop, hold, dir, auto_reload, load_val, limit, presc,
      input  q, busy, done, tc_pulse
   );

   modport slave (
      input  start, stop, hold, dir, auto_reload, load_val, limit, presc,
      output q, busy, done, tc_pulse
   );
endinterface

// File: rtl/updown_count_core.sv
// rtl/updown_count_core.sv - n-bit loadable up/down counter datapath; load has priority over enable
module updown_count_core
   import updown_ctrl_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         en,
   input  logic         dir,
   output logic [N-1:0] q
);
   localparam logic [N-1:0] ONE = N'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (en) begin
         q <= (dir == DIR_DOWN) ? q - ONE : q + ONE;
      end
   end
endmodule

// File: rtl/updown_count_ctrl.sv
// rtl/updown_count_ctrl.sv - sequencing FSM, prescaler, config latches and terminal compare around the counter core
module updown_count_ctrl
   import updown_ctrl_pkg::*;
#(
   parameter int N       = 4,
   parameter int PRESC_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   updown_count_ctrl_if.slave  bus
);
   localparam logic [N-1:0] ONE = N'(1);

   state_t             state;
   logic [PRESC_W-1:0] presc_cnt;
   logic [PRESC_W-1:0] presc_l;
   logic [N-1:0]       load_l;
   logic [N-1:0]       limit_l;
   logic               dir_l;
   logic               auto_l;
   logic               at_limit;

   logic               accept;
   logic               tick;
   logic               reload;
   logic               core_load;
   logic [N-1:0]       core_load_val;
   logic [N-1:0]       step_val;

   assign accept        = bus.start && !bus.stop && (state == IDLE || state == DONE);
   assign tick          = (state == RUN) && !bus.hold && !bus.stop && (presc_cnt == presc_l);
   // at_limit is only set by a step landing on limit, so load_val==limit must traverse first
   assign reload        = tick && auto_l && at_limit;
   assign core_load     = accept || reload;
   assign core_load_val = accept ? bus.load_val : load_l;
   assign step_val      = (dir_l == DIR_DOWN) ? bus.q - ONE : bus.q + ONE;

   updown_count_core #(.N(N)) u_core (
      .clk      (clk),
      .rst      (rst),
      .load     (core_load),
      .load_val (core_load_val),
      .en       (tick && !reload),
      .dir      (dir_l),
      .q        (bus.q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         presc_cnt    <= '0;
         presc_l      <= '0;
         load_l       <= '0;
         limit_l      <= '0;
         dir_l        <= DIR_UP;
         auto_l       <= 1'b0;
         at_limit     <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.tc_pulse <= 1'b0;
      end else begin
         bus.tc_pulse <= 1'b0;
         if (bus.stop) begin
            state     <= IDLE;
            presc_cnt <= '0;
            at_limit  <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
         end else begin
            case (state)
               IDLE, DONE: begin
                  if (accept) begin
                     presc_l   <= bus.presc;
                     load_l    <= bus.load_val;
                     limit_l   <= bus.limit;
                     dir_l     <= bus.dir;
                     auto_l    <= bus.auto_reload;
                     presc_cnt <= '0;
                     at_limit  <= 1'b0;
                     state     <= RUN;
                     bus.busy  <= 1'b1;
                     bus.done  <= 1'b0;
                  end
               end
               RUN: begin
                  if (bus.hold) begin
                     state <= HOLD;
                  end else if (tick) begin
                     presc_cnt <= '0;
                     if (reload) begin
                        at_limit <= 1'b0;
                     end else if (step_val == limit_l) begin
                        bus.tc_pulse <= 1'b1;
                        at_limit     <= 1'b1;
                        if (!auto_l) begin
                           state    <= DONE;
                           bus.busy <= 1'b0;
                           bus.done <= 1'b1;
                        end
                     end
                  end else begin
                     presc_cnt <= presc_cnt + PRESC_W'(1);
                  end
               end
               HOLD: begin
                  if (!bus.hold) state <= RUN;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
